upconverter: RTL and testbench

- Transmit-side counterpart of the receive downconverter. Takes signed 16-bit baseband I/Q and produces a real 16-bit IF sample stream for the DAC: dac_out = I·cos(φ) − Q·sin(φ).
- Carrier comes from an internal phase-accumulator NCO with a quarter-wave sine LUT.
- Runs continuously at DAC rate: one output per clk, 3-cycle pipeline.

---
 rtl/upconverter_pkg.sv | 25 ++
 rtl/upconverter_nco.sv | 100 ++++++++++
 rtl/upconverter.sv | 123 ++++++++++++
 tb/tb_upconverter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/upconverter_pkg.sv
// Shared constants, types and helpers for the transmit upconverter.
package upconverter_pkg;

  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 10;
  localparam int DATA_W  = 16;

  // Dither LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
  } iq_sample_t;

  // Frequency control word for an IF at sample rate f_s (elaboration-time only)
  function automatic logic [PHASE_W-1:0] calc_fcw(input real f_if, input real f_s);
    real ratio;
    ratio = f_if / f_s;
    ratio = ratio - $floor(ratio);
    return PHASE_W'(longint'(ratio * (2.0 ** PHASE_W)));
  endfunction

endpackage

// File: rtl/upconverter_nco.sv
// Phase-accumulator NCO with quarter-wave sine LUT; sin/cos registered so
// they line up with the I/Q capture stage of the upconverter.
// Build option: UPCONVERTER_PHASE_DITHER_EN adds LFSR dither to the LUT address.
module nco_sincos
  import upconverter_pkg::*;
#(
  parameter logic [PHASE_W-1:0] FCW_DEFAULT = 32'h4000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PHASE_W-1:0]       fcw_in,
  input  logic                     fcw_load,
  input  logic                     phase_clr,
  output logic signed [DATA_W-1:0] sin_out,
  output logic signed [DATA_W-1:0] cos_out
);

  localparam int  QW     = 1 << (LUT_AW - 2);
  localparam int  IW     = LUT_AW - 1;
  localparam real TWO_PI = 6.283185307179586;
  localparam real AMP    = real'((1 << (DATA_W - 1)) - 1);

  logic [PHASE_W-1:0]       phase;
  logic [PHASE_W-1:0]       fcw;
  logic [LUT_AW-1:0]        addr;
  logic [1:0]               quad;
  logic [IW-1:0]            idx_fwd;
  logic [IW-1:0]            idx_rev;
  logic signed [DATA_W-1:0] lut [0:QW];
  logic signed [DATA_W-1:0] lut_fwd;
  logic signed [DATA_W-1:0] lut_rev;
  logic signed [DATA_W-1:0] sin_next;
  logic signed [DATA_W-1:0] cos_next;

  // First quadrant of the sine, endpoints included, so 0 and 90 degrees are exact
  for (genvar k = 0; k <= QW; k++) begin : g_lut
    localparam real ANGLE = TWO_PI * real'(k) / real'(1 << LUT_AW);
    localparam int  VAL   = $rtoi(AMP * $sin(ANGLE) + 0.5);
    assign lut[k] = DATA_W'(VAL);
  end

  // Accumulator: clear wins over increment; a new fcw applies from the next edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      fcw   <= FCW_DEFAULT;
    end else begin
      phase <= phase_clr ? '0 : phase + fcw;
      if (fcw_load) fcw <= fcw_in;
    end
  end

`ifdef UPCONVERTER_PHASE_DITHER_EN
  localparam int DW = PHASE_W - LUT_AW;

  logic [15:0]   lfsr;
  logic [DW-1:0] dither;

  // Free-running dither source; only the LUT address sees it, never the accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign dither = DW'(lfsr);
  assign addr   = LUT_AW'((phase + {{LUT_AW{1'b0}}, dither}) >> DW);
`else
  assign addr   = phase[PHASE_W-1 -: LUT_AW];
`endif

  assign quad    = addr[LUT_AW-1 -: 2];
  assign idx_fwd = {1'b0, addr[LUT_AW-3:0]};
  assign idx_rev = IW'(QW) - idx_fwd;
  assign lut_fwd = lut[idx_fwd];
  assign lut_rev = lut[idx_rev];

  // Quadrant folding: mirror the index and/or negate the quarter-wave entry
  always_comb begin
    sin_next = '0;
    cos_next = '0;
    case (quad)
      2'd0: begin sin_next =  lut_fwd; cos_next =  lut_rev; end
      2'd1: begin sin_next =  lut_rev; cos_next = -lut_fwd; end
      2'd2: begin sin_next = -lut_fwd; cos_next = -lut_rev; end
      default: begin sin_next = -lut_rev; cos_next =  lut_fwd; end
    endcase
  end

  // Carrier register, same edge that captures the baseband sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      sin_out <= sin_next;
      cos_out <= cos_next;
    end
  end

endmodule

// File: rtl/upconverter.sv
// Transmit upconverter: dac_out = I*cos - Q*sin with rounding and saturation.
// Input captured at edge N appears on dac_out at edge N+3.
// Build option: UPCONVERTER_PHASE_DITHER_EN (NCO LUT address dither).
module upconverter
  import upconverter_pkg::*;
#(
  parameter logic [PHASE_W-1:0] FCW_DEFAULT = 32'h4000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  input  logic                     in_valid,
  input  logic [PHASE_W-1:0]       fcw_in,
  input  logic                     fcw_load,
  input  logic                     phase_clr,
  output logic signed [DATA_W-1:0] dac_out,
  output logic                     out_valid,
  output logic                     sat_pulse,
  output logic [15:0]              underrun_cnt
);

  localparam logic signed [33:0] ROUND_HALF = 34'sd16384;
  localparam logic signed [33:0] MAX_OUT    = 34'sd32767;
  localparam logic signed [33:0] MIN_OUT    = -34'sd32768;

  iq_sample_t               s1_iq;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_sin;
  logic signed [DATA_W-1:0] s1_cos;
  logic signed [31:0]       s2_ic;
  logic signed [31:0]       s2_qs;
  logic                     s2_valid;
  logic signed [32:0]       s3_diff;
  logic                     s3_valid;
  logic signed [33:0]       shifted;
  logic signed [DATA_W-1:0] sat_value;
  logic                     sat_hit;

  nco_sincos #(
    .FCW_DEFAULT (FCW_DEFAULT)
  ) u_nco (
    .clk       (clk),
    .reset_n   (reset_n),
    .fcw_in    (fcw_in),
    .fcw_load  (fcw_load),
    .phase_clr (phase_clr),
    .sin_out   (s1_sin),
    .cos_out   (s1_cos)
  );

  // S1: capture baseband, stuffing zeros when the source underruns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_iq    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_iq    <= in_valid ? iq_sample_t'{i: i_in, q: q_in} : '0;
      s1_valid <= in_valid;
    end
  end

  // S2: the two mixing products, full 32-bit precision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_ic    <= '0;
      s2_qs    <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_ic    <= 32'($signed(s1_iq.i)) * 32'(s1_cos);
      s2_qs    <= 32'($signed(s1_iq.q)) * 32'(s1_sin);
      s2_valid <= s1_valid;
    end
  end

  // S3: difference with one guard bit so it cannot wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_diff  <= '0;
      s3_valid <= 1'b0;
    end else begin
      s3_diff  <= 33'(s2_ic) - 33'(s2_qs);
      s3_valid <= s2_valid;
    end
  end

  // Round half up back to Q15, then clip to the DAC range
  always_comb begin
    shifted   = (34'(s3_diff) + ROUND_HALF) >>> 15;
    sat_value = shifted[DATA_W-1:0];
    sat_hit   = 1'b0;
    if (shifted > MAX_OUT) begin
      sat_value = 16'sh7FFF;
      sat_hit   = 1'b1;
    end else if (shifted < MIN_OUT) begin
      sat_value = -16'sh8000;
      sat_hit   = 1'b1;
    end
  end

  // Output register feeding the DAC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_out   <= '0;
      out_valid <= 1'b0;
      sat_pulse <= 1'b0;
    end else begin
      dac_out   <= sat_value;
      out_valid <= s3_valid;
      sat_pulse <= sat_hit;
    end
  end

  // Count cycles the baseband source failed to deliver, sticking at full scale
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (!in_valid && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_upconverter.sv
// Scoreboard bench for the upconverter: stimulus pushes hand-computed expected
// outputs, a monitor pops and compares them three edges after capture.
module tb_upconverter;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic               in_valid;
  logic [31:0]        fcw_in;
  logic               fcw_load;
  logic               phase_clr;
  logic signed [15:0] dac_out;
  logic               out_valid;
  logic               sat_pulse;
  logic [15:0]        underrun_cnt;

  typedef struct {
    int due;
    int v;
    int d;
    int s;
    int tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   in_reset = 1'b1;

  // Expected tables (Q15 round half up of I*cos - Q*sin)
  int expA[4] = '{16384, 0, -16383, 0};
  int expB[4] = '{0, -16383, 0, 16384};
  int expC[8] = '{32766, 32767, 32767, 1, -32766, -32768, -32767, -1};
  int satC[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  int expD[5] = '{16384, 16384, 0, -16383, -23170};

  upconverter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_in         (i_in),
    .q_in         (q_in),
    .in_valid     (in_valid),
    .fcw_in       (fcw_in),
    .fcw_load     (fcw_load),
    .phase_clr    (phase_clr),
    .dac_out      (dac_out),
    .out_valid    (out_valid),
    .sat_pulse    (sat_pulse),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; drives one capture slot and queues its expected output
  task automatic applyStimulus(input int i, input int q, input bit v, input bit clr,
                               input bit load, input logic [31:0] fcw,
                               input int ev, input int ed, input int es, input int tag);
    i_in      = 16'(i);
    q_in      = 16'(q);
    in_valid  = v;
    phase_clr = clr;
    fcw_load  = load;
    fcw_in    = fcw;
    sbq.push_back('{cyc + 4, ev, ed, es, tag});
    @(negedge clk);
  endtask

  // Monitor: compares whatever the DUT presents against the queue head
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!in_reset) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          e = sbq.pop_front();
          checkOutput($sformatf("out_valid[%0d]", e.tag), int'(out_valid), e.v);
          checkOutput($sformatf("dac_out[%0d]", e.tag), int'(dac_out), e.d);
          checkOutput($sformatf("sat_pulse[%0d]", e.tag), int'(sat_pulse), e.s);
        end else begin
          checkOutput("idle out_valid", int'(out_valid), 0);
          checkOutput("idle dac_out", int'(dac_out), 0);
          checkOutput("idle sat_pulse", int'(sat_pulse), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset_n   = 1'b0;
    i_in      = '0;
    q_in      = '0;
    in_valid  = 1'b0;
    fcw_in    = '0;
    fcw_load  = 1'b0;
    phase_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset dac_out", int'(dac_out), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset underrun_cnt", int'(underrun_cnt), 0);
    reset_n  = 1'b1;
    in_reset = 1'b0;

    $display("[TB] I-only carrier at default fcw");
    for (int k = 0; k < 8; k++)
      applyStimulus(16384, 0, 1, 0, 0, 0, 1, expA[k % 4], 0, k);
    checkOutput("underrun_cnt before gap", int'(underrun_cnt), 0);

    $display("[TB] Q-only carrier");
    for (int k = 0; k < 8; k++)
      applyStimulus(0, 16384, 1, 0, 0, 0, 1, expB[k % 4], 0, 8 + k);

    $display("[TB] five-cycle underrun");
    for (int k = 0; k < 5; k++)
      applyStimulus(12345, -2222, 0, 0, 0, 0, 0, 0, 0, 16 + k);
    checkOutput("underrun_cnt after gap", int'(underrun_cnt), 5);
    for (int k = 0; k < 4; k++)
      applyStimulus(16384, 0, 1, 0, 0, 0, 1, expA[(k + 1) % 4], 0, 21 + k);
    checkOutput("underrun_cnt after resume", int'(underrun_cnt), 5);

    $display("[TB] fcw_load with phase_clr, full-scale saturation sweep");
    applyStimulus(16384, 0, 1, 1, 1, 32'h2000_0000, 1, 0, 0, 25);
    for (int k = 0; k < 8; k++)
      applyStimulus(32767, -32768, 1, 0, 0, 0, 1, expC[k], satC[k], 26 + k);

    $display("[TB] mid-stream phase_clr");
    for (int k = 0; k < 5; k++)
      applyStimulus(16384, 16384, 1, (k == 0), 0, 0, 1, expD[k], 0, 34 + k);

    $display("[TB] mid-stream reset");
    @(posedge clk);
    #3;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    #1;
    checkOutput("async reset dac_out", int'(dac_out), 0);
    checkOutput("async reset out_valid", int'(out_valid), 0);
    checkOutput("async reset sat_pulse", int'(sat_pulse), 0);
    checkOutput("async reset underrun_cnt", int'(underrun_cnt), 0);
    repeat (2) @(negedge clk);
    checkOutput("held reset out_valid", int'(out_valid), 0);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    checkOutput("underrun_cnt after release", int'(underrun_cnt), 0);

    for (int k = 0; k < 8; k++)
      applyStimulus(16384, 0, 1, 0, 0, 0, 1, expA[k % 4], 0, 40 + k);
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 48 + k);
    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
